// File: rtl/counter_load_mod.sv
// counter_load_mod: loadable modulo counter with a runtime terminal value,
// up/down direction, wrap or saturate limit behaviour, and event flags.
//   clk         rising-edge clock
//   reset_n     asynchronous active-low reset
//   enable      count enable (ignored while load is high)
//   load        synchronous load of data_in, clamped to max_val
//   data_in     load value
//   up_down     direction: 1=up, 0=down
//   sat_mode    limit behaviour: 0=wrap, 1=saturate
//   max_val     terminal value, count range 0..max_val
//   clr_sticky  synchronous clear of ovf_sticky
//   data_out    registered count
//   wrap_pulse  registered, high while data_out shows a freshly wrapped value
//   at_limit    combinational, data_out sits at the limit of the current direction
//   ovf_sticky  registered sticky overflow/underflow flag
module counter_load_mod #(
   parameter int WIDTH     = 8,
   parameter int RESET_VAL = 0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             enable,
   input  logic             load,
   input  logic [WIDTH-1:0] data_in,
   input  logic             up_down,
   input  logic             sat_mode,
   input  logic [WIDTH-1:0] max_val,
   input  logic             clr_sticky,
   output logic [WIDTH-1:0] data_out,
   output logic             wrap_pulse,
   output logic             at_limit,
   output logic             ovf_sticky
);
   logic             up_lim, dn_zero, dn_over, ev, wrp;
   logic [WIDTH-1:0] nxt;
   // >= rather than == so a max_val lowered below the count still wraps/saturates
   assign up_lim   = data_out >= max_val;
   assign dn_zero  = data_out == '0;
   assign dn_over  = data_out > max_val;
   assign at_limit = up_down ? up_lim : dn_zero;
   always_comb begin
      nxt = data_out;
      ev  = 1'b0;
      wrp = 1'b0;
      if (load)
         nxt = (data_in > max_val) ? max_val : data_in;
      else if (enable && up_down) begin
         ev  = up_lim;
         wrp = up_lim && !sat_mode;
         nxt = !up_lim ? data_out + 1'b1 : (sat_mode ? max_val : '0);
      end else if (enable) begin
         // a count above a lowered max_val snaps down to it silently
         ev  = dn_zero;
         wrp = dn_zero && !sat_mode;
         nxt = dn_over ? max_val : (!dn_zero ? data_out - 1'b1 : (sat_mode ? '0 : max_val));
      end
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_out   <= WIDTH'(RESET_VAL);
         wrap_pulse <= 1'b0;
         ovf_sticky <= 1'b0;
      end else begin
         data_out   <= nxt;
         wrap_pulse <= wrp;
         // a new event in the same cycle as a clear keeps the flag set
         ovf_sticky <= ev || (ovf_sticky && !clr_sticky);
      end
   end
endmodule

// File: tb/tb_counter_load_mod.sv
// tb_counter_load_mod: directed scoreboard bench for counter_load_mod (WIDTH=4).
module tb_counter_load_mod;
   localparam int W = 4;
   typedef struct packed {
      logic [W-1:0] d;
      logic         w;
      logic         o;
   } exp_t;
   logic         clk = 0, reset_n = 0, enable = 0, load = 0, up_down = 1, sat_mode = 0, clr_sticky = 0;
   logic [W-1:0] data_in = 0, max_val = 13;
   logic [W-1:0] data_out;
   logic         wrap_pulse, at_limit, ovf_sticky;
   logic [W-1:0] m_d = 0;
   logic         m_w = 0, m_o = 0;
   exp_t         q[$];
   int           tests = 0, fails = 0;

   counter_load_mod #(.WIDTH(W), .RESET_VAL(0)) dut (
      .clk(clk), .reset_n(reset_n), .enable(enable), .load(load), .data_in(data_in),
      .up_down(up_down), .sat_mode(sat_mode), .max_val(max_val), .clr_sticky(clr_sticky),
      .data_out(data_out), .wrap_pulse(wrap_pulse), .at_limit(at_limit), .ovf_sticky(ovf_sticky)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic predict();
      logic [W-1:0] n;
      logic w, ev;
      n = m_d; w = 0; ev = 0;
      if (load) n = (data_in > max_val) ? max_val : data_in;
      else if (enable) begin
         if (up_down) begin
            if (m_d < max_val) n = m_d + 1'b1;
            else begin ev = 1; n = sat_mode ? max_val : '0; w = !sat_mode; end
         end else if (m_d > max_val) n = max_val;
         else if (m_d != 0) n = m_d - 1'b1;
         else begin ev = 1; n = sat_mode ? '0 : max_val; w = !sat_mode; end
      end
      m_o = ev | (m_o & !clr_sticky);
      m_d = n; m_w = w;
      q.push_back({n, w, m_o});
   endtask

   task automatic step(input string tag);
      exp_t e;
      predict();
      @(posedge clk); #1;
      e = q.pop_front();
      chk({tag, ".data"}, 32'(data_out), 32'(e.d));
      chk({tag, ".wrap"}, 32'(wrap_pulse), 32'(e.w));
      chk({tag, ".ovf"}, 32'(ovf_sticky), 32'(e.o));
      chk({tag, ".lim"}, 32'(at_limit), 32'(up_down ? (m_d >= max_val) : (m_d == 0)));
   endtask

   initial begin
      @(posedge clk); #1;
      chk("rst.data", 32'(data_out), 0);
      chk("rst.wrap", 32'(wrap_pulse), 0);
      chk("rst.ovf", 32'(ovf_sticky), 0);
      reset_n = 1;
      // 1: 0..13 wrap counter
      enable = 1;
      for (int i = 0; i < 16; i++) begin
         step("t1");
         chk("t1.seq", 32'(data_out), 32'((i + 1) % 14));
         chk("t1.pulse", 32'(wrap_pulse), 32'(i == 13));
         chk("t1.sticky", 32'(ovf_sticky), 32'(i >= 13));
      end
      // 2: load beats enable, out-of-range load clamps
      for (int i = 0; i < 3; i++) step("t2c");
      chk("t2.five", 32'(data_out), 5);
      load = 1; data_in = 9;
      step("t2a");
      chk("t2.nine", 32'(data_out), 9);
      data_in = 15;
      step("t2b");
      chk("t2.clamp", 32'(data_out), 13);
      // 3: down wrap
      up_down = 0; max_val = 6; data_in = 1;
      step("t3l");
      load = 0;
      step("t3a");
      chk("t3.zero", 32'(data_out), 0);
      chk("t3.lim0", 32'(at_limit), 1);
      step("t3b");
      chk("t3.six", 32'(data_out), 6);
      chk("t3.pulse6", 32'(wrap_pulse), 1);
      step("t3c");
      chk("t3.five", 32'(data_out), 5);
      chk("t3.nopulse", 32'(wrap_pulse), 0);
      // 4: saturate up, sticky clear and set-wins
      sat_mode = 1; up_down = 1; max_val = 10; load = 1; data_in = 9;
      step("t4l");
      load = 0;
      for (int i = 0; i < 4; i++) begin
         step("t4s");
         chk("t4.sat", 32'(data_out), 10);
         chk("t4.nowrap", 32'(wrap_pulse), 0);
      end
      chk("t4.ovf", 32'(ovf_sticky), 1);
      enable = 0; clr_sticky = 1;
      step("t4clr");
      chk("t4.cleared", 32'(ovf_sticky), 0);
      enable = 1;
      step("t4win");
      chk("t4.setwins", 32'(ovf_sticky), 1);
      clr_sticky = 0;
      // 5: max_val lowered below the count
      sat_mode = 0; max_val = 13; load = 1; data_in = 12;
      step("t5l");
      load = 0; max_val = 7;
      step("t5u");
      chk("t5.upwrap", 32'(data_out), 0);
      chk("t5.uppulse", 32'(wrap_pulse), 1);
      max_val = 13; load = 1;
      step("t5l2");
      load = 0; max_val = 7; up_down = 0;
      step("t5d");
      chk("t5.dnsnap", 32'(data_out), 7);
      chk("t5.dnnopulse", 32'(wrap_pulse), 0);
      // max_val == 0: every enabled cycle wraps
      max_val = 0; up_down = 1;
      for (int i = 0; i < 3; i++) begin
         step("tz");
         chk("tz.pulse", 32'(wrap_pulse), 1);
      end
      // 6: asynchronous reset mid-count
      max_val = 13; load = 1; data_in = 8;
      step("t6l");
      load = 0;
      #3 reset_n = 0;
      #1;
      chk("t6.data", 32'(data_out), 0);
      chk("t6.wrap", 32'(wrap_pulse), 0);
      chk("t6.ovf", 32'(ovf_sticky), 0);
      m_d = 0; m_w = 0; m_o = 0;
      @(posedge clk); #1;
      chk("t6.held", 32'(data_out), 0);
      reset_n = 1;
      step("t6r");
      chk("t6.restart", 32'(data_out), 1);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
